// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/grant bundle between the requesters and the shared-port arbiter
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    modport master (output req, done, input gnt, sel, busy, timeout);
    modport slave (input req, done, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared memory port mux, holding each grant until done, abort or hold timeout
module mem_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CW = 5
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam bit TO_EN = MAX_HOLD != 0;
    localparam logic [CW-1:0] LIM = CW'(TO_EN ? MAX_HOLD - 1 : 0);
    state_t state_q, state_d;
    logic [1:0] ptr_q, ptr_d, sel_q, sel_d, win;
    logic [3:0] gnt_q, gnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic to_q, to_d, found, lim, arb;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            sel_q <= '0;
            gnt_q <= '0;
            hold_q <= '0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            gnt_q <= gnt_d;
            hold_q <= hold_d;
            to_q <= to_d;
        end
    end
    always_comb begin
        found = 1'b0;
        win = ptr_q;
        // descending scan so the closest index to ptr wins
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                found = 1'b1;
                win = ptr_q + 2'(k);
            end
        end
        lim = TO_EN && state_q == BUSY && hold_q == LIM;
        arb = state_q == IDLE || bus.done || !bus.req[sel_q] || lim;
        state_d = state_q;
        ptr_d = ptr_q;
        sel_d = sel_q;
        gnt_d = gnt_q;
        hold_d = &hold_q ? hold_q : hold_q + 1'b1;
        to_d = lim && !bus.done && bus.req[sel_q];
        if (arb) begin
            hold_d = '0;
            state_d = found ? BUSY : IDLE;
            gnt_d = found ? 4'b0001 << win : 4'b0000;
            sel_d = found ? win : sel_q;
            ptr_d = found ? win + 2'd1 : ptr_q;
        end
    end
    assign bus.gnt = gnt_q;
    assign bus.sel = sel_q;
    assign bus.busy = |gnt_q;
    assign bus.timeout = to_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors; outputs packed as {timeout, busy, sel, gnt}
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    mem_port_arbiter_if bus ();
    mem_port_arbiter #(.MAX_HOLD(4), .CW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] outs();
        return {bus.timeout, bus.busy, bus.sel, bus.gnt};
    endfunction
    logic [7:0] rr [5] = '{8'h41, 8'h52, 8'h64, 8'h78, 8'h41};
    initial begin
        bus.req = 4'b0000;
        bus.done = 1'b0;
        tick();
        tick();
        chk("reset", outs(), 8'h00);
        rst_n = 1'b1;
        bus.req = 4'b0100;
        tick();
        chk("single_gnt", outs(), 8'h64);
        bus.req = 4'b0000;
        bus.done = 1'b1;
        tick();
        chk("single_done", outs(), 8'h20);
        tick();
        chk("idle_done", outs(), 8'h20);
        bus.done = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req = 4'b1111;
        tick();
        chk("rr_first", outs(), rr[0]);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("rr_hold%0d", i), outs(), rr[i-1]);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            chk($sformatf("rr_gnt%0d", i), outs(), rr[i]);
        end
        bus.req = 4'b0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("rr_idle", outs(), 8'h00);
        bus.req = 4'b0001;
        tick();
        chk("to_gnt", outs(), 8'h41);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("to_hold%0d", i), outs(), 8'h41);
        end
        tick();
        chk("to_pulse", outs(), 8'hC1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("lim_hold%0d", i), outs(), 8'h41);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("lim_done", outs(), 8'h41);
        bus.req = 4'b0000;
        tick();
        chk("abort_idle", outs(), 8'h00);
        bus.req = 4'b1010;
        tick();
        chk("abort_gnt1", outs(), 8'h52);
        bus.req = 4'b1000;
        tick();
        chk("abort_gnt3", outs(), 8'h78);
        rst_n = 1'b0;
        tick();
        chk("mid_reset", outs(), 8'h00);
        rst_n = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("post_reset", outs(), 8'h41);
        bus.req = 4'b0100;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("noise_gnt", outs(), 8'h64);
        for (int i = 0; i < 3; i++) begin
            bus.req = (i % 2 == 0) ? 4'b0110 : 4'b0100;
            tick();
            chk($sformatf("noise%0d", i), outs(), 8'h64);
        end
        bus.req = 4'b0000;
        tick();
        chk("final_idle", outs(), 8'h20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin scheduler that shares one 4-input datapath resource (the shared memory/bus port selected by the 2-bit-select 4:1 mux) among four requesters.
- Drives the mux select and a one-hot grant.
- Holds the grant for the whole transaction until done, requester abort, or hold timeout.
- Sits between the pipeline/DMA requesters and the shared-port mux in the MIPS datapath.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; 0 disables the timeout.
- CW, 5, hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  4  request per requester; level, held high until the transaction completes.
- done  input  1  shared resource reports completion of the current granted transaction.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  mux select = index of the granted requester, registered.
- busy  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant was force-released by MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at an edge): gnt=0, sel=0, busy=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. A reset mid-transaction drops the grant immediately at that edge.
- Internal state: state in {IDLE, BUSY}; ptr[1:0] is the highest-priority index; hold_cnt[CW-1:0].
- Arbitration function: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the winner is the first index with req set.
- IDLE:
  - If req != 0 at an edge: gnt <= onehot(winner), sel <= winner, ptr <= winner+1 (mod 4), hold_cnt <= 0, state <= BUSY.
  - Latency from req sampled to gnt visible is 1 cycle.
  - Otherwise remain IDLE; gnt=0; sel holds its last value.
- BUSY, with granted index g. A release occurs at an edge if any of:
  - (a) done=1;
  - (b) req[g]=0 (abort);
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- Without a release: hold_cnt <= hold_cnt+1; gnt and sel are unchanged.
- On release: rearbitrate at the same edge with ptr already equal to g+1, so there is no bubble.
  - If a winner exists: new grant as in IDLE, and state stays BUSY.
  - Otherwise: gnt <= 0, state <= IDLE.
  - g may be regranted only if it is the sole requester.
- timeout <= 1 for exactly one cycle after a release caused solely by (c). If done=1 on the same edge as the limit is reached, the release counts as done and timeout stays 0.
- done while IDLE is ignored.
- req changes on non-granted lines never disturb the current grant.
- sel and gnt are always consistent: gnt = onehot(sel) whenever busy=1.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,…; no requester waits more than 3 grants.
- ptr wraps 3 -> 0.
- hold_cnt saturates and never wraps while BUSY.

Test Plan:
- Reset then single request: rst_n low 2 cycles, req=4'b0100 -> next cycle gnt=4'b0100, sel=2, busy=1; done pulse -> following cycle gnt=0, busy=0.
- All requesters, done every 2nd cycle: req=4'b1111 held, ptr=0 -> grants 0,1,2,3,0 in order, back-to-back with no idle cycle; sel=0,1,2,3,0.
- Timeout with MAX_HOLD=4: req=4'b0001 held, done never asserted -> gnt=0001 for exactly 4 cycles, then timeout=1 for 1 cycle; regranted to 0 on the same edge since it is the sole requester.
- Simultaneous done and limit with MAX_HOLD=4: done=1 at the 4th held cycle -> release with timeout=0. Abort: req[g] dropped mid-grant with req=4'b1010 -> grant moves to the next index in rotation.
- Reset mid-transaction: gnt=4'b1000, busy=1, rst_n=0 -> next edge gnt=0, sel=0, ptr=0. With req=4'b1001 after reset -> grant 0 first.
- Done while idle and noise on ungranted lines: done pulses with req=0 -> no grant. Toggling req[1] while gnt=4'b0100 -> gnt unchanged.
